// File: rtl/fetch_pkg.sv
// Purpose: shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // issue or hold a request at pc
    ST_SKID  = 2'd1,  // a word is parked in the skid while decode stalls
    ST_DRAIN = 2'd2   // waiting out a stale request after a redirect
  } fetch_state_e;

  // MIPS-style instruction field bit positions.
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // All-zero word held in IF/ID and the skid after reset.
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam int PC_INC = 4;

endpackage

// File: rtl/fetch_skid.sv
// Purpose: one-entry buffer holding a fetched word and its pc+4 while decode stalls.
// Latency: loaded word is visible on the outputs the cycle after load.
// Backpressure: none of its own; the owner must not load while full.
// Ports: clock/nreset; load/unload/clear strobes (clear wins, then load);
//        in_word/in_pcplus4 captured on load; full, word, pcplus4 are registered.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int PCWIDTH = 32
) (
  input  logic               clock,
  input  logic               nreset,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [31:0]        in_word,
  input  logic [PCWIDTH-1:0] in_pcplus4,
  output logic               full,
  output logic [31:0]        word,
  output logic [PCWIDTH-1:0] pcplus4
);

  logic               full_q, full_d;
  logic [31:0]        word_q, word_d;
  logic [PCWIDTH-1:0] pcplus4_q, pcplus4_d;

  always_comb begin
    full_d    = full_q;
    word_d    = word_q;
    pcplus4_d = pcplus4_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d    = 1'b1;
      word_d    = in_word;
      pcplus4_d = in_pcplus4;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      full_q    <= 1'b0;
      word_q    <= NOP_WORD;
      pcplus4_q <= '0;
    end else begin
      full_q    <= full_d;
      word_q    <= word_d;
      pcplus4_q <= pcplus4_d;
    end
  end

  assign full    = full_q;
  assign word    = word_q;
  assign pcplus4 = pcplus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch: PC, req/ack to imem, IF/ID register with field split.
// Latency: imemack in cycle N gives valid instruction fields in cycle N+1.
// Backpressure: stall holds IF/ID; one extra word parks in a skid, then requests stop.
// Ports: clock/nreset; imemreq/imemaddr/imemack/imemdata memory handshake;
//        stall from decode; redirect/redirectpc from the branch unit;
//        valid, op, rs, rt, rd, shamt, fn, imm16, target26, pcplus4 to decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                 PCWIDTH = 32,
  parameter logic [PCWIDTH-1:0] RESETPC = '0
) (
  input  logic               clock,
  input  logic               nreset,
  output logic               imemreq,
  output logic [PCWIDTH-1:0] imemaddr,
  input  logic               imemack,
  input  logic [31:0]        imemdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PCWIDTH-1:0] redirectpc,
  output logic               valid,
  output logic [5:0]         op,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         fn,
  output logic [15:0]        imm16,
  output logic [25:0]        target26,
  output logic [PCWIDTH-1:0] pcplus4
);

  fetch_state_e       state_q, state_d;
  logic [PCWIDTH-1:0] pc_q, pc_d;
  logic [PCWIDTH-1:0] drain_addr_q, drain_addr_d;  // address of the stale request
  logic               run_q, run_d;                // low only in the first cycle after reset
  logic               valid_q, valid_d;
  logic [31:0]        ifid_word_q, ifid_word_d;
  logic [PCWIDTH-1:0] pcplus4_q, pcplus4_d;

  logic               skid_load, skid_unload, skid_clear, skid_full;
  logic [31:0]        skid_word;
  logic [PCWIDTH-1:0] skid_pcplus4;
  logic [PCWIDTH-1:0] pc_next;
  logic               ack_live;

  fetch_skid #(.PCWIDTH(PCWIDTH)) u_skid (
    .clock      (clock),
    .nreset     (nreset),
    .load       (skid_load),
    .unload     (skid_unload),
    .clear      (skid_clear),
    .in_word    (imemdata),
    .in_pcplus4 (pc_next),
    .full       (skid_full),
    .word       (skid_word),
    .pcplus4    (skid_pcplus4)
  );

  // Request is decoded from registered state only, so no path from imemack.
  assign imemreq  = run_q && (((state_q == ST_FETCH) && !skid_full) || (state_q == ST_DRAIN));
  assign imemaddr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  assign pc_next  = pc_q + PCWIDTH'(PC_INC);
  assign ack_live = imemreq && imemack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    run_d        = 1'b1;
    valid_d      = stall ? valid_q : 1'b0;  // decode consumes whenever not stalled
    ifid_word_d  = ifid_word_q;
    pcplus4_d    = pcplus4_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;

    if (redirect) begin
      pc_d       = {redirectpc[PCWIDTH-1:2], 2'b00};
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      if (imemreq && !imemack) begin
        // The outstanding request must complete at its original address.
        state_d = ST_DRAIN;
        if (state_q != ST_DRAIN) drain_addr_d = pc_q;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (ack_live) begin
            pc_d = pc_next;
            if (valid_q && stall) begin
              skid_load = 1'b1;
              state_d   = ST_SKID;
            end else begin
              ifid_word_d = imemdata;
              pcplus4_d   = pc_next;
              valid_d     = 1'b1;
            end
          end
        end
        ST_SKID: begin
          if (!stall) begin
            skid_unload = 1'b1;
            ifid_word_d = skid_word;
            pcplus4_d   = skid_pcplus4;
            valid_d     = 1'b1;
            state_d     = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (ack_live) state_d = ST_FETCH;  // stale data dropped
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESETPC;
      drain_addr_q <= '0;
      run_q        <= 1'b0;
      valid_q      <= 1'b0;
      ifid_word_q  <= NOP_WORD;
      pcplus4_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      run_q        <= run_d;
      valid_q      <= valid_d;
      ifid_word_q  <= ifid_word_d;
      pcplus4_q    <= pcplus4_d;
    end
  end

  assign valid    = valid_q;
  assign op       = ifid_word_q[OP_HI:OP_LO];
  assign rs       = ifid_word_q[RS_HI:RS_LO];
  assign rt       = ifid_word_q[RT_HI:RT_LO];
  assign rd       = ifid_word_q[RD_HI:RD_LO];
  assign shamt    = ifid_word_q[SH_HI:SH_LO];
  assign fn       = ifid_word_q[FN_HI:FN_LO];
  assign imm16    = ifid_word_q[IMM_HI:IMM_LO];
  assign target26 = ifid_word_q[TGT_HI:TGT_LO];
  assign pcplus4  = pcplus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock;
  logic        nreset;
  logic        imemreq;
  logic [31:0] imemaddr;
  logic        imemack;
  logic [31:0] imemdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectpc;
  logic        valid;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  fn;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic [31:0] pcplus4;

  fetch_stage #(.PCWIDTH(32), .RESETPC(RST_PC)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .imemreq    (imemreq),
    .imemaddr   (imemaddr),
    .imemack    (imemack),
    .imemdata   (imemdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirectpc (redirectpc),
    .valid      (valid),
    .op         (op),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .fn         (fn),
    .imm16      (imm16),
    .target26   (target26),
    .pcplus4    (pcplus4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Distinct, address-derived instruction word returned by the memory model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2] ^ 6'h23, a[27:2] ^ 26'h1234567};
  endfunction

  task automatic check_word(input string name, input logic [31:0] w);
    check({name, "_fields"}, {32'h0, op, rs, rt, rd, shamt, fn}, {32'h0, w});
    check({name, "_imm16"}, {48'h0, imm16}, {48'h0, w[15:0]});
    check({name, "_target26"}, {38'h0, target26}, {38'h0, w[25:0]});
  endtask

  // Memory model: acks after mem_lat cycles of a held request (0 = same cycle).
  int unsigned mem_lat = 0;
  int unsigned wait_cnt;
  assign imemack  = imemreq && (wait_cnt >= mem_lat);
  assign imemdata = mem_word(imemaddr);

  always @(posedge clock or negedge nreset) begin
    if (!nreset)                    wait_cnt <= 0;
    else if (imemreq && !imemack)   wait_cnt <= wait_cnt + 1;
    else                            wait_cnt <= 0;
  end

  // Scoreboard: accepted fetches are pushed in order; each decode consumption pops one.
  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pp4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_pc = RST_PC;
  logic        stale  = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!nreset) begin
      exp_q.delete();
      stale  = 1'b0;
      exp_pc = RST_PC;
    end else if (redirect) begin
      if (imemreq && !imemack) stale = 1'b1;
      else if (imemreq)        stale = 1'b0;
      exp_q.delete();
      exp_pc = redirectpc & ~32'h3;
    end else begin
      if (imemreq && imemack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          check("sb_fetch_addr", {32'h0, imemaddr}, {32'h0, exp_pc});
          exp_q.push_back('{w: mem_word(exp_pc), pp4: exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_valid", {63'h0, valid}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check_word("sb_word", e.w);
          check("sb_pcplus4", {32'h0, pcplus4}, {32'h0, e.pp4});
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [31:0] rp;
    logic [31:0] first_addr;
    logic [31:0] second_addr;
    logic [31:0] pp4;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    vecs[1] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    vecs[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 32'h0000_0004};
    vecs[4] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000, 32'h8000_0000};

    nreset     = 1'b0;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectpc = 32'h0;
    mem_lat    = 0;

    // Reset values.
    #3;
    check("rst_imemreq", {63'h0, imemreq}, 64'h0);
    check("rst_valid", {63'h0, valid}, 64'h0);
    check_word("rst_word", 32'h0);
    check("rst_pcplus4", {32'h0, pcplus4}, 64'h0);
    cyc();
    cyc();
    nreset = 1'b1;

    // Back-to-back fetch with a same-cycle-ack memory.
    for (int i = 0; i < 5 && !imemreq; i++) cyc();
    check("boot_req", {63'h0, imemreq}, 64'h1);
    check("boot_addr0", {32'h0, imemaddr}, {32'h0, RST_PC});
    check("boot_valid0", {63'h0, valid}, 64'h0);
    cyc();
    check("boot_addr1", {32'h0, imemaddr}, 64'h4);
    check("boot_valid1", {63'h0, valid}, 64'h1);
    check("boot_pp4_1", {32'h0, pcplus4}, 64'h4);
    check_word("boot_word_a", mem_word(32'h0));
    cyc();
    check("boot_addr2", {32'h0, imemaddr}, 64'h8);
    check("boot_pp4_2", {32'h0, pcplus4}, 64'h8);
    check_word("boot_word_b", mem_word(32'h4));

    // Stall while valid: word at 0x8 parks in the skid and requests stop.
    stall = 1'b1;
    cyc();
    check("skid_req_off", {63'h0, imemreq}, 64'h0);
    check("skid_valid_hold", {63'h0, valid}, 64'h1);
    check("skid_pp4_hold", {32'h0, pcplus4}, 64'h8);
    cyc();
    check("skid_req_off2", {63'h0, imemreq}, 64'h0);
    stall = 1'b0;
    cyc();
    check("skid_drain_pp4", {32'h0, pcplus4}, 64'hC);
    check_word("skid_drain_word", mem_word(32'h8));
    check("skid_resume_req", {63'h0, imemreq}, 64'h1);
    check("skid_resume_addr", {32'h0, imemaddr}, 64'hC);
    cyc();
    check("skid_next_pp4", {32'h0, pcplus4}, 64'h10);

    // Table: redirect coinciding with ack, alignment and wraparound.
    for (int v = 0; v < 5; v++) begin
      redirect   = 1'b1;
      redirectpc = vecs[v].rp;
      cyc();
      redirect = 1'b0;
      check($sformatf("vec%0d_first_addr", v), {32'h0, imemaddr}, {32'h0, vecs[v].first_addr});
      check($sformatf("vec%0d_valid_off", v), {63'h0, valid}, 64'h0);
      cyc();
      check($sformatf("vec%0d_second_addr", v), {32'h0, imemaddr}, {32'h0, vecs[v].second_addr});
      check($sformatf("vec%0d_pcplus4", v), {32'h0, pcplus4}, {32'h0, vecs[v].pp4});
      check($sformatf("vec%0d_valid_on", v), {63'h0, valid}, 64'h1);
    end

    // Redirect while a slow request is outstanding: drain it, then fetch the target.
    redirect   = 1'b1;
    redirectpc = 32'h4;
    cyc();
    redirect = 1'b0;
    mem_lat  = 3;
    check("drain_req_at4", {32'h0, imemaddr}, 64'h4);
    cyc();
    redirect   = 1'b1;
    redirectpc = 32'h100;
    cyc();
    redirect = 1'b0;
    check("drain_hold_req", {63'h0, imemreq}, 64'h1);
    check("drain_hold_addr", {32'h0, imemaddr}, 64'h4);
    cyc();
    check("drain_ack_addr", {32'h0, imemaddr}, 64'h4);
    cyc();
    check("drain_new_req", {63'h0, imemreq}, 64'h1);
    check("drain_new_addr", {32'h0, imemaddr}, 64'h100);
    check("drain_discarded", {63'h0, valid}, 64'h0);
    mem_lat = 0;
    cyc();
    check("drain_valid", {63'h0, valid}, 64'h1);
    check("drain_pp4", {32'h0, pcplus4}, 64'h104);

    // Redirect while stalled with the skid full.
    stall = 1'b1;
    cyc();
    check("skidredir_req_off", {63'h0, imemreq}, 64'h0);
    redirect   = 1'b1;
    redirectpc = 32'h103;
    cyc();
    redirect = 1'b0;
    check("skidredir_valid", {63'h0, valid}, 64'h0);
    check("skidredir_req", {63'h0, imemreq}, 64'h1);
    check("skidredir_addr", {32'h0, imemaddr}, 64'h100);
    cyc();
    check("skidredir_load_valid", {63'h0, valid}, 64'h1);
    check("skidredir_pp4", {32'h0, pcplus4}, 64'h104);
    check_word("skidredir_word", mem_word(32'h100));
    stall = 1'b0;
    cyc();
    cyc();

    // Reset asserted while a request waits for an ack.
    redirect   = 1'b1;
    redirectpc = 32'h40;
    cyc();
    redirect = 1'b0;
    mem_lat  = 255;
    cyc();
    cyc();
    check("midrst_req_held", {63'h0, imemreq}, 64'h1);
    check("midrst_addr_held", {32'h0, imemaddr}, 64'h40);
    #2;
    nreset = 1'b0;
    #1;
    check("midrst_req_off", {63'h0, imemreq}, 64'h0);
    check("midrst_valid", {63'h0, valid}, 64'h0);
    check("midrst_pp4", {32'h0, pcplus4}, 64'h0);
    check_word("midrst_word", 32'h0);
    cyc();
    nreset  = 1'b1;
    mem_lat = 0;
    for (int i = 0; i < 5 && !imemreq; i++) cyc();
    check("midrst_req_again", {63'h0, imemreq}, 64'h1);
    check("midrst_first_addr", {32'h0, imemaddr}, {32'h0, RST_PC});
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
